// File: rtl/adc_config_queue.sv
// Queues {addr,data} ADC register writes and issues them one at a time to the three-wire config mux.
// First start pulse 3 cycles after a write to an idle queue; paced by config_busy_i; writes to a full queue drop.
module adc_config_queue #(
  parameter int DEPTH       = 8,
  parameter int GAP_CYCLES  = 16,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [2:0]               wr_addr,
  input  logic [15:0]              wr_data,
  input  logic                     flush,
  input  logic                     clr_status,
  input  logic                     config_busy_i,
  output logic                     request_o,
  output logic                     config_start_o,
  output logic [2:0]               config_addr_o,
  output logic [15:0]              config_data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     idle_o,
  output logic                     overflow_o,
  output logic [7:0]               retry_count_o,
  output logic [15:0]              done_count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ARM       = 3'd1;
  localparam logic [2:0] S_ISSUE     = 3'd2;
  localparam logic [2:0] S_WAIT_ACK  = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_GAP       = 3'd5;

  logic [2:0]    state;
  logic [18:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    ack_tmr;
  logic [7:0]    gap_cnt;
  logic          has_data;
  logic          push;
  logic          pop;
  logic          drop;
  logic          retry_evt;

  assign has_data  = (level_o != '0);
  assign full_o    = (level_o == LW'(DEPTH));
  assign idle_o    = !has_data && (state == S_IDLE);
  assign push      = wr_en && !full_o && !flush;
  assign drop      = wr_en && full_o && !flush;
  assign pop       = (state == S_ISSUE) && has_data;
  // The timer is reloaded on every start pulse, so expiry is never tested in a pulse cycle.
  assign retry_evt = (state == S_WAIT_ACK) && !config_busy_i && !config_start_o && (ack_tmr <= 8'd1);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wr_addr, wr_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_o    <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        level_o <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        level_o <= level_o + LW'(push) - LW'(pop);
      end
      if (drop)            overflow_o <= 1'b1;
      else if (clr_status) overflow_o <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      request_o      <= 1'b0;
      config_start_o <= 1'b0;
      config_addr_o  <= '0;
      config_data_o  <= '0;
      ack_tmr        <= '0;
      gap_cnt        <= '0;
      done_count_o   <= '0;
    end else begin
      config_start_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (has_data && !flush) begin
            state     <= S_ARM;
            request_o <= 1'b1;
          end
        end
        S_ARM: begin
          if (!has_data || flush) begin
            state     <= S_IDLE;
            request_o <= 1'b0;
          end else if (!config_busy_i) begin
            state          <= S_ISSUE;
            config_start_o <= 1'b1;
            {config_addr_o, config_data_o} <= mem[rd_ptr];
          end
        end
        S_ISSUE: begin
          ack_tmr <= 8'(ACK_TIMEOUT);
          state   <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (config_busy_i)       state          <= S_WAIT_DONE;
          else if (config_start_o) ack_tmr        <= 8'(ACK_TIMEOUT);
          else if (retry_evt)      config_start_o <= 1'b1;
          else                     ack_tmr        <= ack_tmr - 8'd1;
        end
        S_WAIT_DONE: begin
          if (!config_busy_i) begin
            done_count_o <= done_count_o + 16'd1;
            gap_cnt      <= 8'(GAP_CYCLES);
            state        <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt <= 8'd1) begin
            if (has_data && !flush) begin
              state <= S_ARM;
            end else begin
              state     <= S_IDLE;
              request_o <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: begin
          state     <= S_IDLE;
          request_o <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_status)                    retry_count_o <= '0;
    else if (retry_evt && retry_count_o != 8'hff) retry_count_o <= retry_count_o + 8'd1;
  end

endmodule

// File: tb/tb_adc_config_queue.sv
// Randomized and directed bench for adc_config_queue against a transaction-level queue model.
module tb_adc_config_queue;
  localparam int DEPTH = 8;
  localparam int GAP   = 16;
  localparam int ACK   = 8;

  logic        clk = 1'b0;
  logic        rst, wr_en, flush, clr_status, busy;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        request_o, config_start_o, full_o, idle_o, overflow_o;
  logic [2:0]  config_addr_o;
  logic [15:0] config_data_o;
  logic [3:0]  level_o;
  logic [7:0]  retry_count_o;
  logic [15:0] done_count_o;

  always #5 clk = ~clk;

  adc_config_queue #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .flush(flush), .clr_status(clr_status), .config_busy_i(busy),
    .request_o(request_o), .config_start_o(config_start_o),
    .config_addr_o(config_addr_o), .config_data_o(config_data_o),
    .level_o(level_o), .full_o(full_o), .idle_o(idle_o), .overflow_o(overflow_o),
    .retry_count_o(retry_count_o), .done_count_o(done_count_o)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;
  bit stub_en = 0;
  int hold_left = 0, delay_left = 0, hold_len = 0;

  // Model: queue contents plus the timestamps of the transfer in flight.
  logic [18:0] mq[$];
  bit          m_own, m_start, m_ovf, m_gap, m_pop;
  logic [2:0]  m_addr;
  logic [15:0] m_data;
  int          m_retry, m_done, m_xfer, m_first, m_pulse, m_gap_end, n;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit issue, retry, was_full;
    issue = 0;
    retry = 0;
    if (rst) begin
      mq.delete();
      m_own = 0; m_start = 0; m_ovf = 0; m_gap = 0; m_pop = 0;
      m_addr = '0; m_data = '0; m_retry = 0; m_done = 0; m_xfer = 0;
      n++;
      return;
    end
    was_full = (mq.size() == DEPTH);
    if (m_xfer == 1) begin
      if (busy && n != m_first) m_xfer = 2;
      else if (!busy && n == m_pulse + ACK) retry = 1;
    end else if (m_xfer == 2) begin
      if (!busy) begin
        m_done = (m_done + 1) % 65536;
        m_xfer = 0;
        m_gap = 1;
        m_gap_end = n + GAP;
      end
    end else if (m_gap) begin
      if (n == m_gap_end) begin
        m_gap = 0;
        m_own = (mq.size() != 0) && !flush;
      end
    end else if (!m_own) begin
      m_own = (mq.size() != 0) && !flush;
    end else if (mq.size() == 0 || flush) begin
      m_own = 0;
    end else if (!busy) begin
      issue = 1;
      m_xfer = 1;
      m_first = n + 1;
      m_pulse = n + 1;
      {m_addr, m_data} = mq[0];
    end
    if (retry) m_pulse = n + 1;
    m_start = issue || retry;
    if (flush) mq.delete();
    else begin
      if (m_pop && mq.size() > 0) void'(mq.pop_front());
      if (wr_en && !was_full) mq.push_back({wr_addr, wr_data});
    end
    m_pop = issue;
    if (wr_en && was_full && !flush) m_ovf = 1;
    else if (clr_status) m_ovf = 0;
    if (clr_status) m_retry = 0;
    else if (retry && m_retry < 255) m_retry++;
    n++;
  endtask

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      cmp("request", request_o, m_own);
      cmp("start", config_start_o, m_start);
      cmp("level", level_o, mq.size());
      cmp("full", full_o, mq.size() == DEPTH);
      cmp("idle", idle_o, mq.size() == 0 && !m_own);
      cmp("overflow", overflow_o, m_ovf);
      cmp("retry", retry_count_o, m_retry);
      cmp("done", done_count_o, m_done);
      if (m_start) begin
        cmp("addr", config_addr_o, m_addr);
        cmp("data", config_data_o, m_data);
      end
    end
  end

  // Mux stub: answers most start pulses after 1..3 cycles, occasionally ignores one,
  // and runs short autonomous transfers while software does not own the bus.
  task automatic stub_drive();
    if (hold_left > 0) begin
      busy = 1;
      hold_left--;
    end else if (delay_left > 0) begin
      busy = 0;
      delay_left--;
      if (delay_left == 0) hold_left = hold_len;
    end else begin
      busy = 0;
      if (config_start_o) begin
        if ($urandom_range(7) != 0) begin
          delay_left = $urandom_range(3, 1);
          hold_len   = $urandom_range(6, 1);
        end
      end else if (!request_o && $urandom_range(19) == 0) begin
        hold_left = $urandom_range(8, 1);
      end
    end
  endtask

  task automatic tick();
    if (stub_en) stub_drive();
    model_step();
    @(negedge clk);
    wr_en = 0;
    flush = 0;
    clr_status = 0;
    rst = 0;
  endtask

  task automatic stub_on();
    hold_left = 0;
    delay_left = 0;
    stub_en = 1;
  endtask

  task automatic stub_off();
    stub_en = 0;
    busy = 0;
    for (int i = 0; i < 20; i++) tick();
  endtask

  initial begin
    rst = 1; wr_en = 0; flush = 0; clr_status = 0; busy = 0; wr_addr = '0; wr_data = '0;
    n = 0;
    @(negedge clk);
    chk_en = 1;
    rst = 1;
    tick();
    rst = 1;
    tick();
    cmp("rst_request", request_o, 0);
    cmp("rst_start", config_start_o, 0);
    cmp("rst_addr", config_addr_o, 0);
    cmp("rst_data", config_data_o, 0);
    cmp("rst_level", level_o, 0);
    cmp("rst_full", full_o, 0);
    cmp("rst_idle", idle_o, 1);
    cmp("rst_overflow", overflow_o, 0);
    cmp("rst_retry", retry_count_o, 0);
    cmp("rst_done", done_count_o, 0);

    // Single write, busy high 5..20.
    wr_en = 1; wr_addr = 3'd0; wr_data = 16'h7cbc;
    tick();
    for (int c = 1; c <= 40; c++) begin
      busy = (c >= 5 && c <= 20);
      if (c == 1) begin cmp("sw_level1", level_o, 1); cmp("sw_req1", request_o, 0); end
      if (c == 2) begin cmp("sw_req2", request_o, 1); cmp("sw_start2", config_start_o, 0); end
      if (c == 3) begin
        cmp("sw_start3", config_start_o, 1);
        cmp("sw_addr3", config_addr_o, 0);
        cmp("sw_data3", config_data_o, 16'h7cbc);
      end
      if (c == 21) cmp("sw_done21", done_count_o, 0);
      if (c == 22) cmp("sw_done22", done_count_o, 1);
      if (c == 37) cmp("sw_req37", request_o, 1);
      if (c == 38) begin cmp("sw_req38", request_o, 0); cmp("sw_idle38", idle_o, 1); end
      tick();
    end

    // Mux already busy when the write arrives.
    busy = 1; wr_en = 1; wr_addr = 3'd5; wr_data = 16'h1234;
    tick();
    for (int c = 1; c <= 40; c++) begin
      busy = (c <= 9) || (c == 13) || (c == 14);
      if (c == 5) begin cmp("be_req5", request_o, 1); cmp("be_start5", config_start_o, 0); end
      if (c == 10) cmp("be_start10", config_start_o, 0);
      if (c == 11) begin cmp("be_start11", config_start_o, 1); cmp("be_data11", config_data_o, 16'h1234); end
      tick();
    end
    cmp("be_done", done_count_o, 2);

    // Four words queued, flush while the first transfer is in WAIT_DONE.
    for (int c = 0; c <= 45; c++) begin
      wr_en = (c <= 3); wr_addr = 3'(c + 1); wr_data = 16'($urandom);
      busy = (c >= 5 && c <= 10);
      flush = (c == 8);
      if (c == 5) cmp("fl_level5", level_o, 3);
      if (c == 9) cmp("fl_level9", level_o, 0);
      if (c == 11) cmp("fl_done11", done_count_o, 2);
      if (c == 12) cmp("fl_done12", done_count_o, 3);
      tick();
    end
    cmp("fl_done_end", done_count_o, 3);
    cmp("fl_idle_end", idle_o, 1);

    // Ordered drain of three words through the mux stub.
    stub_on();
    for (int c = 0; c < 400; c++) begin
      wr_en = (c < 3); wr_addr = 3'(c + 1); wr_data = 16'h0a00 + 16'(c);
      tick();
    end
    stub_off();
    cmp("dr_done", done_count_o, 6);

    // Overflow with the mux held busy.
    busy = 1;
    for (int c = 0; c <= 8; c++) begin
      wr_en = 1; wr_addr = 3'(c); wr_data = 16'($urandom);
      tick();
    end
    cmp("ov_level", level_o, 8);
    cmp("ov_full", full_o, 1);
    cmp("ov_flag", overflow_o, 1);
    cmp("ov_start", config_start_o, 0);
    clr_status = 1;
    tick();
    cmp("ov_clr", overflow_o, 0);
    stub_on();
    for (int c = 0; c < 700; c++) tick();
    stub_off();
    cmp("ov_done", done_count_o, 14);
    cmp("ov_level_end", level_o, 0);

    // Ack timeout: the mux never answers.
    clr_status = 1;
    tick();
    wr_en = 1; wr_addr = 3'd2; wr_data = 16'hc0de;
    tick();
    for (int c = 1; c <= 2320; c++) begin
      busy = 0;
      if (c == 3) cmp("to_start3", config_start_o, 1);
      if (c == 11) cmp("to_start11", config_start_o, 0);
      if (c == 12) begin
        cmp("to_start12", config_start_o, 1);
        cmp("to_data12", config_data_o, 16'hc0de);
        cmp("to_retry12", retry_count_o, 1);
      end
      if (c == 21) begin cmp("to_start21", config_start_o, 1); cmp("to_retry21", retry_count_o, 2); end
      if (c == 2297) cmp("to_retry2297", retry_count_o, 254);
      if (c == 2307) begin
        cmp("to_start2307", config_start_o, 1);
        cmp("to_addr2307", config_addr_o, 2);
        cmp("to_retry_sat", retry_count_o, 255);
      end
      tick();
    end
    for (int c = 0; c < 40; c++) begin
      busy = (c < 2);
      tick();
    end
    cmp("to_done", done_count_o, 15);
    cmp("to_idle", idle_o, 1);

    // Reset during WAIT_DONE.
    for (int c = 0; c <= 45; c++) begin
      wr_en = (c == 0); wr_addr = 3'd6; wr_data = 16'hbeef;
      busy = (c >= 5 && c <= 30);
      rst = (c == 10);
      if (c == 9) cmp("rs_addr9", config_addr_o, 6);
      if (c == 11) begin
        cmp("rs_request", request_o, 0);
        cmp("rs_start", config_start_o, 0);
        cmp("rs_addr", config_addr_o, 0);
        cmp("rs_data", config_data_o, 0);
        cmp("rs_level", level_o, 0);
        cmp("rs_full", full_o, 0);
        cmp("rs_idle", idle_o, 1);
        cmp("rs_overflow", overflow_o, 0);
        cmp("rs_retry", retry_count_o, 0);
        cmp("rs_done", done_count_o, 0);
      end
      tick();
    end

    // Randomized traffic against the model.
    stub_on();
    for (int i = 0; i < 3000; i++) begin
      wr_en = ($urandom_range(3) == 0);
      wr_addr = 3'($urandom);
      wr_data = 16'($urandom);
      flush = ($urandom_range(63) == 0);
      clr_status = ($urandom_range(63) == 0);
      rst = ($urandom_range(699) == 0);
      tick();
    end
    stub_en = 0;
    chk_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
